vga_window_scheduler: RTL and testbench

Frame-synchronous overlay controller that sits after the 640x480@60 VGA sync generator. It consumes that generator's Ready/address/VSYNC outputs and schedules up to NUM_WIN rectangular colour windows over a background pixel stream. Software writes window configuration into a staging bank at any time. A commit handshake transfers staging to the active bank only at frame start, so windows never tear mid-frame. The block also runs a per-frame blink scheduler and a fixed-priority arbiter between overlapping windows.

---
 rtl/vga_window_scheduler.sv | 153 +++++++++++++++
 tb/tb_vga_window_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_scheduler.sv
// Overlay scheduler for up to NUM_WIN rectangular colour windows on a VGA pixel stream.
// Software edits a staging bank; the active bank is reloaded only at frame start so windows never tear.
module vga_window_scheduler #(
    parameter int NUM_WIN      = 4,
    parameter int ADDR_W       = 11,
    parameter int RGB_W        = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic               Ready_Sig,
    input  logic               VSYNC_Sig,
    input  logic [ADDR_W-1:0]  Column_Addr_Sig,
    input  logic [ADDR_W-1:0]  Row_Addr_Sig,
    input  logic [RGB_W-1:0]   bg_rgb,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic               cfg_commit,
    output logic               cfg_busy,
    output logic [RGB_W-1:0]   vga_rgb,
    output logic               vga_de,
    output logic [NUM_WIN-1:0] win_hit
);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] x_start;
        logic [ADDR_W-1:0] x_end;
        logic [ADDR_W-1:0] y_start;
        logic [ADDR_W-1:0] y_end;
        logic [RGB_W-1:0]  color;
        logic              enable;
        logic              blink;
    } win_t;

    state_t             state;
    state_t             state_next;
    win_t               stg [NUM_WIN];
    win_t               act [NUM_WIN];
    logic               vsync_d;
    logic               frame_start;
    logic [CNT_W-1:0]   frame_cnt;
    logic               blink_phase;
    logic [1:0]         widx;
    logic               wr_ok;
    logic [NUM_WIN-1:0] hit_next;
    logic [RGB_W-1:0]   rgb_next;
    logic               found;

    assign frame_start = vsync_d & ~VSYNC_Sig;
    assign cfg_busy    = (state != IDLE);
    assign widx        = cfg_addr[4:3];
    assign wr_ok       = cfg_we && (state == IDLE) && (int'(widx) < NUM_WIN);

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A commit seen in the same cycle as frame_start waits for the following frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_commit) state_next = PENDING;
            PENDING: if (frame_start) state_next = COPY;
            COPY:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) stg[i] <= '0;
        end else if (wr_ok) begin
            case (cfg_addr[2:0])
                3'd0: stg[widx].x_start <= cfg_wdata[ADDR_W-1:0];
                3'd1: stg[widx].x_end   <= cfg_wdata[ADDR_W-1:0];
                3'd2: stg[widx].y_start <= cfg_wdata[ADDR_W-1:0];
                3'd3: stg[widx].y_end   <= cfg_wdata[ADDR_W-1:0];
                3'd4: stg[widx].color   <= cfg_wdata[RGB_W-1:0];
                3'd5: begin
                    stg[widx].enable <= cfg_wdata[0];
                    stg[widx].blink  <= cfg_wdata[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) act[i] <= '0;
        end else if (state == COPY) begin
            for (int i = 0; i < NUM_WIN; i++) act[i] <= stg[i];
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            vsync_d     <= 1'b1;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_d <= VSYNC_Sig;
            if (frame_start) begin
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Lowest index wins among overlapping windows.
    always_comb begin
        hit_next = '0;
        rgb_next = bg_rgb;
        found    = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (!found && Ready_Sig && act[i].enable && (!act[i].blink || !blink_phase) &&
                (act[i].x_start <= Column_Addr_Sig) && (Column_Addr_Sig <= act[i].x_end) &&
                (act[i].y_start <= Row_Addr_Sig) && (Row_Addr_Sig <= act[i].y_end)) begin
                found       = 1'b1;
                hit_next[i] = 1'b1;
                rgb_next    = act[i].color;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            vga_de  <= 1'b0;
            vga_rgb <= '0;
            win_hit <= '0;
        end else begin
            vga_de  <= Ready_Sig;
            vga_rgb <= Ready_Sig ? rgb_next : '0;
            win_hit <= hit_next;
        end
    end
endmodule

// File: tb/tb_vga_window_scheduler.sv
// Bench for vga_window_scheduler: drives a shrunken VGA raster with random background pixels
// and compares every output cycle with a rule-level model of the window overlay.
module tb_vga_window_scheduler;
    localparam int NW        = 4;
    localparam int BF        = 2;
    localparam int ACT_COLS  = 200;
    localparam int LINE_CYC  = 208;
    localparam int ACT_ROWS  = 16;
    localparam int LINES     = 18;
    localparam int FRAME_CYC = LINE_CYC * LINES;
    localparam int FS_IDX    = ACT_ROWS * LINE_CYC;
    localparam int EXP_W     = 1 + NW + 16;

    logic          vga_clk;
    logic          rst_n;
    logic          Ready_Sig;
    logic          VSYNC_Sig;
    logic [10:0]   Column_Addr_Sig;
    logic [10:0]   Row_Addr_Sig;
    logic [15:0]   bg_rgb;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [15:0]   cfg_wdata;
    logic          cfg_commit;
    logic          cfg_busy;
    logic [15:0]   vga_rgb;
    logic          vga_de;
    logic [NW-1:0] win_hit;

    vga_window_scheduler #(
        .NUM_WIN(NW), .ADDR_W(11), .RGB_W(16), .BLINK_FRAMES(BF)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .Ready_Sig(Ready_Sig), .VSYNC_Sig(VSYNC_Sig),
        .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig), .bg_rgb(bg_rgb),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .vga_rgb(vga_rgb), .vga_de(vga_de), .win_hit(win_hit)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    typedef struct {
        int          xs;
        int          xe;
        int          ys;
        int          ye;
        logic [15:0] color;
        logic        en;
        logic        blink;
    } mwin_t;

    mwin_t            m_stg [NW];
    mwin_t            m_act [NW];
    logic             m_pending;
    logic             m_tail;
    logic             m_vs_prev;
    int               m_fs_cnt;
    logic [EXP_W-1:0] exp_q[$];

    int   pix_err;
    int   de_cnt;
    int   hit_cnt [NW];
    logic busy_tr [FRAME_CYC];
    int   n_checks;
    int   n_pass;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_stg[i] = '{0, 0, 0, 0, 16'h0, 1'b0, 1'b0};
            m_act[i] = '{0, 0, 0, 0, 16'h0, 1'b0, 1'b0};
        end
        m_pending = 1'b0;
        m_tail    = 1'b0;
        m_vs_prev = 1'b1;
        m_fs_cnt  = 0;
    endtask

    task automatic clear_stats();
        pix_err = 0;
        de_cnt  = 0;
        for (int i = 0; i < NW; i++) hit_cnt[i] = 0;
        for (int k = 0; k < FRAME_CYC; k++) busy_tr[k] = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the registered output of this cycle.
    task automatic drive_cycle(input logic rst, input logic rdy, input logic vs, input int col,
                               input int row, input logic we, input logic [4:0] addr,
                               input logic [15:0] wd, input logic commit, input int idx);
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] got;
        logic [15:0]      bg;
        logic [NW-1:0]    h;
        logic [15:0]      rgb;
        logic             busy_now;
        int               win;
        int               w;
        bg              = 16'($urandom);
        rst_n           = rst;
        Ready_Sig       = rdy;
        VSYNC_Sig       = vs;
        Column_Addr_Sig = rdy ? 11'(col) : 11'd0;
        Row_Addr_Sig    = rdy ? 11'(row) : 11'd0;
        bg_rgb          = bg;
        cfg_we          = we;
        cfg_addr        = addr;
        cfg_wdata       = wd;
        cfg_commit      = commit;
        if (!rst) begin
            model_reset();
            exp_v = '0;
        end else begin
            win = -1;
            for (int i = NW - 1; i >= 0; i--) begin
                if (rdy && m_act[i].en && (!m_act[i].blink || ((m_fs_cnt / BF) % 2 == 0)) &&
                    col >= m_act[i].xs && col <= m_act[i].xe &&
                    row >= m_act[i].ys && row <= m_act[i].ye) win = i;
            end
            h     = (win >= 0) ? NW'(1 << win) : '0;
            rgb   = !rdy ? 16'h0 : (win >= 0) ? m_act[win].color : bg;
            exp_v = {rdy, h, rgb};
            busy_now = m_pending || m_tail;
            m_tail   = 1'b0;
            w        = int'(addr[4:3]);
            if (!busy_now && we && w < NW) begin
                case (addr[2:0])
                    3'd0: m_stg[w].xs = int'(wd[10:0]);
                    3'd1: m_stg[w].xe = int'(wd[10:0]);
                    3'd2: m_stg[w].ys = int'(wd[10:0]);
                    3'd3: m_stg[w].ye = int'(wd[10:0]);
                    3'd4: m_stg[w].color = wd;
                    3'd5: begin
                        m_stg[w].en    = wd[0];
                        m_stg[w].blink = wd[1];
                    end
                    default: ;
                endcase
            end
            if (m_vs_prev && !vs) begin
                m_fs_cnt++;
                if (m_pending) begin
                    m_act     = m_stg;
                    m_pending = 1'b0;
                    m_tail    = 1'b1;
                end
            end
            m_vs_prev = vs;
            if (!busy_now && commit) m_pending = 1'b1;
        end
        exp_q.push_back(exp_v);
        @(posedge vga_clk);
        #1;
        got   = {vga_de, win_hit, vga_rgb};
        exp_v = exp_q.pop_front();
        if (got !== exp_v) pix_err++;
        if (vga_de === 1'b1) de_cnt++;
        for (int i = 0; i < NW; i++) if (win_hit[i] === 1'b1) hit_cnt[i]++;
        if (idx >= 0 && idx < FRAME_CYC) busy_tr[idx] = cfg_busy;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 5'd0, 16'h0, 1'b0, -1);
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [15:0] data);
        drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b1, addr, data, 1'b0, -1);
    endtask

    task automatic commit_idle();
        drive_cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 5'd0, 16'h0, 1'b1, -1);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 5'd0, 16'h0, 1'b0, -1);
        idle_cycles(2);
    endtask

    task automatic set_window(input int w, input int xs, input int xe, input int ys, input int ye,
                              input logic [15:0] color, input logic [1:0] ctrl);
        cfg_write({2'(w), 3'd0}, 16'(xs));
        cfg_write({2'(w), 3'd1}, 16'(xe));
        cfg_write({2'(w), 3'd2}, 16'(ys));
        cfg_write({2'(w), 3'd3}, 16'(ye));
        cfg_write({2'(w), 3'd4}, color);
        cfg_write({2'(w), 3'd5}, {14'd0, ctrl});
    endtask

    task automatic disable_all();
        for (int w = 0; w < NW; w++) cfg_write({2'(w), 3'd5}, 16'h0);
    endtask

    task automatic run_frame(input int commit_at, input int commit2_at, input int we_at,
                             input logic [4:0] we_addr, input logic [15:0] we_data);
        int k;
        clear_stats();
        for (int line = 0; line < LINES; line++) begin
            for (int x = 0; x < LINE_CYC; x++) begin
                k = line * LINE_CYC + x;
                drive_cycle(1'b1, (line < ACT_ROWS) && (x < ACT_COLS), line != ACT_ROWS, x, line,
                            k == we_at, we_addr, we_data, (k == commit_at) || (k == commit2_at), k);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b1, 5, 5, 1'b1, 5'd5, 16'h1, 1'b1, -1);
        n_checks++; if (vga_de !== 1'b0) $display("FAIL reset_de: got %b want 0", vga_de); else n_pass++;
        n_checks++; if (vga_rgb !== 16'h0) $display("FAIL reset_rgb: got %h want 0000", vga_rgb); else n_pass++;
        n_checks++; if (win_hit !== '0) $display("FAIL reset_hit: got %b want 0000", win_hit); else n_pass++;
        n_checks++; if (cfg_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", cfg_busy); else n_pass++;
        idle_cycles(2);
        n_checks++; if (cfg_busy !== 1'b0) $display("FAIL reset_commit_ignored: busy=%b want 0", cfg_busy); else n_pass++;
    endtask

    task automatic test_background();
        int total;
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        total = 0;
        for (int i = 0; i < NW; i++) total += hit_cnt[i];
        n_checks++; if (pix_err !== 0) $display("FAIL bg_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
        n_checks++; if (de_cnt !== ACT_COLS * ACT_ROWS) $display("FAIL bg_de_count: got %0d want %0d", de_cnt, ACT_COLS * ACT_ROWS); else n_pass++;
        n_checks++; if (total !== 0) $display("FAIL bg_hits: got %0d want 0", total); else n_pass++;
    endtask

    task automatic test_single_window();
        int   c;
        logic ok;
        c = 8 * LINE_CYC + 50;
        set_window(0, 100, 199, 5, 14, 16'hF800, 2'b01);
        run_frame(c, -1, -1, 5'd0, 16'h0);
        ok = 1'b1;
        for (int k = c; k <= FS_IDX; k++) if (busy_tr[k] !== 1'b1) ok = 1'b0;
        n_checks++; if (hit_cnt[0] !== 0) $display("FAIL single_no_tear: hits=%0d want 0", hit_cnt[0]); else n_pass++;
        n_checks++; if (pix_err !== 0) $display("FAIL single_commit_frame_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
        n_checks++; if (busy_tr[c - 1] !== 1'b0) $display("FAIL single_busy_before: got %b want 0", busy_tr[c - 1]); else n_pass++;
        n_checks++; if (ok !== 1'b1) $display("FAIL single_busy_held: got %b want 1", ok); else n_pass++;
        n_checks++; if (busy_tr[FS_IDX + 1] !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy_tr[FS_IDX + 1]); else n_pass++;
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        n_checks++; if (hit_cnt[0] !== 1000) $display("FAIL single_hits: got %0d want 1000", hit_cnt[0]); else n_pass++;
        n_checks++; if (pix_err !== 0) $display("FAIL single_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
    endtask

    task automatic test_priority();
        disable_all();
        set_window(0, 0, 99, 2, 3, 16'hF800, 2'b01);
        set_window(2, 50, 149, 2, 3, 16'h001F, 2'b01);
        commit_idle();
        vsync_pulse();
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        n_checks++; if (hit_cnt[0] !== 200) $display("FAIL prio_win0: got %0d want 200", hit_cnt[0]); else n_pass++;
        n_checks++; if (hit_cnt[2] !== 100) $display("FAIL prio_win2: got %0d want 100", hit_cnt[2]); else n_pass++;
        n_checks++; if (pix_err !== 0) $display("FAIL prio_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        disable_all();
        set_window(1, 0, 9, 0, 0, 16'h07E0, 2'b01);
        cfg_write({2'd1, 3'd6}, 16'hFFFF);
        commit_idle();
        vsync_pulse();
        run_frame(500, 900, 900, {2'd1, 3'd4}, 16'hFFFF);
        n_checks++; if (busy_tr[FS_IDX + 1] !== 1'b0) $display("FAIL busy_single_copy: busy=%b want 0", busy_tr[FS_IDX + 1]); else n_pass++;
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        n_checks++; if (busy_tr[10] !== 1'b0) $display("FAIL busy_no_second_commit: busy=%b want 0", busy_tr[10]); else n_pass++;
        n_checks++; if (hit_cnt[1] !== 10) $display("FAIL busy_hits: got %0d want 10", hit_cnt[1]); else n_pass++;
        commit_idle();
        vsync_pulse();
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        n_checks++; if (pix_err !== 0) $display("FAIL busy_write_dropped: mismatches=%0d want 0", pix_err); else n_pass++;
    endtask

    task automatic test_blink();
        logic vis;
        int   want;
        int   shown;
        int   hidden;
        shown  = 0;
        hidden = 0;
        disable_all();
        set_window(1, 20, 59, 1, 2, 16'hABCD, 2'b11);
        commit_idle();
        vsync_pulse();
        for (int f = 0; f < 4; f++) begin
            vis  = ((m_fs_cnt / BF) % 2) == 0;
            want = vis ? 80 : 0;
            if (vis) shown++; else hidden++;
            run_frame(-1, -1, -1, 5'd0, 16'h0);
            n_checks++; if (hit_cnt[1] !== want) $display("FAIL blink_frame%0d: hits=%0d want %0d", f, hit_cnt[1], want); else n_pass++;
            n_checks++; if (pix_err !== 0) $display("FAIL blink_pixels%0d: mismatches=%0d want 0", f, pix_err); else n_pass++;
        end
        n_checks++; if (shown * hidden === 0) $display("FAIL blink_both_phases: shown=%0d hidden=%0d want both >0", shown, hidden); else n_pass++;
    endtask

    task automatic test_reversed();
        disable_all();
        set_window(1, 0, 4, 0, 0, 16'h1111, 2'b01);
        set_window(2, 0, 199, 10, 5, 16'h2222, 2'b01);
        set_window(3, 150, 50, 0, 15, 16'h3333, 2'b01);
        commit_idle();
        vsync_pulse();
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        n_checks++; if (hit_cnt[1] !== 5) $display("FAIL rev_ref_window: got %0d want 5", hit_cnt[1]); else n_pass++;
        n_checks++; if (hit_cnt[2] !== 0) $display("FAIL rev_y: got %0d want 0", hit_cnt[2]); else n_pass++;
        n_checks++; if (hit_cnt[3] !== 0) $display("FAIL rev_x: got %0d want 0", hit_cnt[3]); else n_pass++;
        n_checks++; if (pix_err !== 0) $display("FAIL rev_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
    endtask

    task automatic test_reset_pending();
        int total;
        disable_all();
        set_window(0, 0, 199, 0, 15, 16'h1234, 2'b01);
        commit_idle();
        idle_cycles(3);
        n_checks++; if (cfg_busy !== 1'b1) $display("FAIL rstp_pending: busy=%b want 1", cfg_busy); else n_pass++;
        drive_cycle(1'b1, 1'b1, 1'b1, 10, 0, 1'b0, 5'd0, 16'h0, 1'b0, -1);
        drive_cycle(1'b0, 1'b1, 1'b1, 11, 0, 1'b0, 5'd0, 16'h0, 1'b0, -1);
        n_checks++; if (cfg_busy !== 1'b0) $display("FAIL rstp_busy: got %b want 0", cfg_busy); else n_pass++;
        n_checks++; if ({vga_de, vga_rgb} !== 17'h0) $display("FAIL rstp_inflight: de=%b rgb=%h want 0/0000", vga_de, vga_rgb); else n_pass++;
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        run_frame(-1, -1, -1, 5'd0, 16'h0);
        total = 0;
        for (int i = 0; i < NW; i++) total += hit_cnt[i];
        n_checks++; if (total !== 0) $display("FAIL rstp_dropped: hits=%0d want 0", total); else n_pass++;
        n_checks++; if (pix_err !== 0) $display("FAIL rstp_pixels: mismatches=%0d want 0", pix_err); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        clear_stats();
        test_reset();
        test_background();
        test_single_window();
        test_priority();
        test_busy_ignore();
        test_blink();
        test_reversed();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
